// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    FILL    = 2'd1,
    RUN     = 2'd2
  } det_state_e;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with loadable pattern and optional overlap.
// Define MATCH_COUNT_EN to add the saturating match_cnt output (cleared by cnt_clr).
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic             armed
`ifdef MATCH_COUNT_EN
  , output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int unsigned FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_pattern_detector: PAT_W out of range");
  end

  det_state_e       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] win_q, win_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;

  logic [PAT_W-1:0] win_shift;
  logic [FW-1:0]    fill_inc;
  logic             hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNARMED;
      pat_q   <= '0;
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign win_shift = {win_q[PAT_W-2:0], din};
  assign fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
  assign hit       = (win_shift == pat_q) && (fill_inc == FILL_FULL);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    win_d   = win_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    unique case (state_q)
      UNARMED: begin
        if (load) begin
          pat_d   = pat_in;
          win_d   = '0;
          fill_d  = '0;
          state_d = FILL;
        end
      end
      FILL, RUN: begin
        // load discards a coincident data bit, so it is tested before din_vld
        if (load) begin
          pat_d   = pat_in;
          win_d   = '0;
          fill_d  = '0;
          state_d = FILL;
        end else if (din_vld) begin
          win_d  = win_shift;
          fill_d = fill_inc;
          if (fill_inc == FILL_FULL) begin
            state_d = RUN;
          end
          if (hit) begin
            match_d = 1'b1;
            if (!overlap) begin
              win_d   = '0;
              fill_d  = '0;
              state_d = FILL;
            end
          end
        end
      end
      default: state_d = UNARMED;
    endcase
  end

  always_comb begin
    armed = (state_q != UNARMED);
    match = match_q;
  end

`ifdef MATCH_COUNT_EN
  // counts on the completing edge so match_cnt updates together with match
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match_d),
    .clr(cnt_clr),
    .q  (match_cnt)
  );
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  localparam int unsigned CNT_W_UNUSED = CNT_W;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed, table-driven bench for seq_pattern_detector (PAT_W=4, CNT_W=2).
module tb_seq_pattern_detector;

  localparam int unsigned PW = 4;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din = 1'b0;
  logic          din_vld = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] pat_in = '0;
  logic          overlap = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          match;
  logic          armed;
`ifdef MATCH_COUNT_EN
  logic [CW-1:0] match_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .PAT_W(PW),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .load     (load),
    .pat_in   (pat_in),
    .overlap  (overlap),
    .cnt_clr  (cnt_clr),
    .match    (match),
    .armed    (armed)
`ifdef MATCH_COUNT_EN
    , .match_cnt(match_cnt)
`endif
  );

  typedef struct {
    logic          r;
    logic          ld;
    logic [PW-1:0] pat;
    logic          vld;
    logic          d;
    logic          ovl;
    logic          clr;
    logic          em;
    logic          ea;
    int unsigned   ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ld, input logic [PW-1:0] pat,
                              input logic vld, input logic d, input logic ovl,
                              input logic clr, input logic em, input logic ea,
                              input int unsigned ec);
    vec_t t;
    t.r = r; t.ld = ld; t.pat = pat; t.vld = vld; t.d = d; t.ovl = ovl;
    t.clr = clr; t.em = em; t.ea = ea; t.ec = ec;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string name);
    @(negedge clk);
    rst = t.r; load = t.ld; pat_in = t.pat; din_vld = t.vld; din = t.d;
    overlap = t.ovl; cnt_clr = t.clr;
    @(posedge clk);
    #1;
    checks++;
    if (match !== t.em) begin
      errors++;
      $display("FAIL %s match: got %b expected %b", name, match, t.em);
    end
    checks++;
    if (armed !== t.ea) begin
      errors++;
      $display("FAIL %s armed: got %b expected %b", name, armed, t.ea);
    end
`ifdef MATCH_COUNT_EN
    checks++;
    if (match_cnt !== CW'(t.ec)) begin
      errors++;
      $display("FAIL %s match_cnt: got %0d expected %0d", name, match_cnt, t.ec);
    end
`endif
  endtask

  initial begin
    //                r  ld pat      vld d  ovl clr  em ea  cnt
    // reset
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0,  0, 0, 0)); // unarmed ignores bits
    // scenario 1: 1011
    tbl.push_back(mk(0, 1, 4'b1011, 0, 0, 0, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0,  1, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0,  0, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1,  0, 1, 0));
    // scenario 2: 1010 overlapping
    tbl.push_back(mk(0, 1, 4'b1010, 0, 0, 1, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0,  1, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  0, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0,  1, 1, 2));
    // scenario 3: same stream, non-overlapping (load with cnt_clr)
    tbl.push_back(mk(0, 1, 4'b1010, 0, 0, 0, 1,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0,  1, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0,  0, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0,  0, 1, 1));
    // scenario 6: saturation at 3, clear beats coincident match
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1,  0, 1, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 1, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  1, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  1, 1, 2));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  1, 1, 3));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  1, 1, 3));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  1, 1, 3));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 1,  1, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  1, 1, 1));
    // reset in a match cycle overrides everything
    tbl.push_back(mk(1, 1, 4'b1111, 1, 1, 1, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0,  0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // scenario 4a: gaps between bits, match timed from last valid bit
    apply(mk(0, 1, 4'b1011, 0, 0, 1, 1, 0, 1, 0), "gap_load");
    apply(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1, 0), "gap_b1");
    apply(mk(0, 0, 4'b0000, 0, 0, 1, 0, 0, 1, 0), "gap_idle1");
    apply(mk(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1, 0), "gap_b2");
    apply(mk(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1, 0), "gap_idle2");
    apply(mk(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1, 0), "gap_idle3");
    apply(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1, 0), "gap_b3");
    apply(mk(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1, 0), "gap_idle4");
    apply(mk(0, 0, 4'b0000, 1, 1, 1, 0, 1, 1, 1), "gap_b4");
    apply(mk(0, 0, 4'b0000, 0, 0, 1, 0, 0, 1, 1), "gap_after");

    // scenario 4b: load together with 3rd bit discards it
    apply(mk(0, 1, 4'b1011, 0, 0, 1, 1, 0, 1, 0), "ld3_load");
    apply(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1, 0), "ld3_b1");
    apply(mk(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1, 0), "ld3_b2");
    apply(mk(0, 1, 4'b1011, 1, 1, 1, 0, 0, 1, 0), "ld3_b3load");
    apply(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1, 0), "ld3_b4");
    apply(mk(0, 0, 4'b0000, 0, 0, 1, 0, 0, 1, 0), "ld3_after");

    // scenario 5: reset mid-fill, bits ignored until reload
    apply(mk(0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 0), "rst_clr");
    apply(mk(0, 1, 4'b1011, 0, 0, 0, 0, 0, 1, 0), "rst_load");
    apply(mk(0, 0, 4'b0000, 1, 1, 0, 0, 0, 1, 0), "rst_b1");
    apply(mk(0, 0, 4'b0000, 1, 0, 0, 0, 0, 1, 0), "rst_b2");
    apply(mk(0, 0, 4'b0000, 1, 1, 0, 0, 0, 1, 0), "rst_b3");
    apply(mk(1, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 0), "rst_hit");
    apply(mk(0, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 0), "rst_p1");
    apply(mk(0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0), "rst_p2");
    apply(mk(0, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 0), "rst_p3");
    apply(mk(0, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 0), "rst_p4");
    apply(mk(0, 1, 4'b1011, 0, 0, 0, 0, 0, 1, 0), "rst_reload");
    apply(mk(0, 0, 4'b0000, 1, 1, 0, 0, 0, 1, 0), "rst_q1");
    apply(mk(0, 0, 4'b0000, 1, 0, 0, 0, 0, 1, 0), "rst_q2");
    apply(mk(0, 0, 4'b0000, 1, 1, 0, 0, 0, 1, 0), "rst_q3");
    apply(mk(0, 0, 4'b0000, 1, 1, 0, 0, 1, 1, 1), "rst_q4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
